// File: rtl/ram_sp_init_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sp_init_pkg
//  Description : Shared types and helpers for the self-clearing single-port
//                RAM. Holds the clear-sequencer state encoding, the byte
//                width constant, the byte-enable width helper and the per-lane
//                write-merge function.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_sp_init_pkg;

    localparam int BYTE_W = 8;

    // Clear sequencer states; IDLE is only left through reset.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Number of byte lanes in a word of data_w bits.
    function automatic int be_width(input int data_w);
        return data_w / BYTE_W;
    endfunction

    // Byte-masked write data for one lane: the new byte when the lane is
    // enabled, otherwise the byte already stored.
    function automatic logic [BYTE_W-1:0] lane_merge(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              lane_en
    );
        return lane_en ? new_byte : old_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ram_clear_seq
//  Description : Post-reset clear sequencer. Walks the clear counter from 0 to
//                DEPTH-1, asserting clr_we one word per cycle, then parks in
//                IDLE with ready high.
//  Ports       : clk      in  clock, rising edge
//                rst      in  synchronous active-high reset
//                clr_we   out clear write enable for the storage array
//                clr_addr out word address being cleared
//                ready    out clear done, user requests accepted
//  Revision    : 1.0  initial release
// ============================================================================
module ram_clear_seq
    import ram_sp_init_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        clr_we      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                // The write issued at a reset edge would be redone anyway;
                // suppressing it keeps the array quiet while rst is held.
                clr_we = ~rst;
                if (r_cnt == c_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign clr_addr = r_cnt;
    assign ready    = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/ram_sp_init.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sp_init
//  Description : Parametrised single-port synchronous RAM with byte-lane write
//                enables, registered read with valid flag, and a hardware
//                self-clear that fills every word with INIT_VAL after reset.
//  Ports       : clk      in  clock, rising edge
//                rst      in  synchronous active-high reset
//                address  in  word address for read/write
//                WR       in  write strobe
//                RD       in  read strobe
//                be       in  byte-lane write enables
//                Din      in  write data
//                Do       out registered read data
//                rd_valid out one-cycle flag marking new read data on Do
//                ready    out clear done, requests accepted
//  Revision    : 1.0  initial release
// ============================================================================
module ram_sp_init
    import ram_sp_init_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 8,
    parameter int              DEPTH    = 256,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  WR,
    input  logic                  RD,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     Din,
    output logic [DATA_W-1:0]     Do,
    output logic                  rd_valid,
    output logic                  ready
);

    localparam int              c_be_w  = be_width(DATA_W);
    localparam logic [ADDR_W:0] c_depth = DEPTH[ADDR_W:0];

    generate
        if (((DATA_W % 8) != 0) || (DEPTH < 1) || (DEPTH > (1 << ADDR_W))) begin : g_param_check
            $error("ram_sp_init: DATA_W must be a multiple of 8 and 1 <= DEPTH <= 2**ADDR_W");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_ready;
    logic              w_in_range;
    logic              w_user_we;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] r_do;
    logic              r_rd_valid;

    ram_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr),
        .ready    (w_ready)
    );

    // Addresses at or above DEPTH have no storage behind them.
    assign w_in_range = ({1'b0, address} < c_depth);

    // User writes only once the clear is done; the clear owns the port before.
    assign w_user_we = w_ready & ~rst & WR & w_in_range;
    assign w_we      = w_clr_we | w_user_we;
    assign w_waddr   = w_clr_we ? w_clr_addr : address;
    assign w_old     = r_mem[w_waddr];

    generate
        for (genvar gi = 0; gi < c_be_w; gi++) begin : g_lane
            assign w_merged[gi*BYTE_W +: BYTE_W] =
                lane_merge(w_old[gi*BYTE_W +: BYTE_W], Din[gi*BYTE_W +: BYTE_W], be[gi]);
        end
    endgenerate

    assign w_wdata = w_clr_we ? INIT_VAL : w_merged;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Read samples the array before this edge's write lands, giving
    // read-before-write when RD and WR hit the same word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_do       <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_ready && RD) begin
            r_do       <= w_in_range ? r_mem[address] : '0;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign Do       = r_do;
    assign rd_valid = r_rd_valid;
    assign ready    = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_init.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_sp_init
//  Description : Self-checking bench for ram_sp_init. Instance a is the
//                default 256x32 configuration; instance b is DEPTH=200 with a
//                nonzero INIT_VAL to exercise out-of-range handling and the
//                clear value. A word-array reference model tracks instance a.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_sp_init;

    localparam logic [31:0] c_init_b = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_WR, a_RD, a_rd_valid, a_ready;
    logic [7:0]  a_address;
    logic [3:0]  a_be;
    logic [31:0] a_Din, a_Do;
    logic        b_rst, b_WR, b_RD, b_rd_valid, b_ready;
    logic [7:0]  b_address;
    logic [3:0]  b_be;
    logic [31:0] b_Din, b_Do;

    ram_sp_init #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .INIT_VAL(32'h0)) u_dut_a (
        .clk(clk), .rst(a_rst), .address(a_address), .WR(a_WR), .RD(a_RD), .be(a_be),
        .Din(a_Din), .Do(a_Do), .rd_valid(a_rd_valid), .ready(a_ready)
    );

    ram_sp_init #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .INIT_VAL(c_init_b)) u_dut_b (
        .clk(clk), .rst(b_rst), .address(b_address), .WR(b_WR), .RD(b_RD), .be(b_be),
        .Din(b_Din), .Do(b_Do), .rd_valid(b_rd_valid), .ready(b_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model for instance a: word array plus expected read outputs.
    logic [31:0] ref_a [256];
    logic [31:0] exp_do;
    logic        exp_vld;

    task automatic model_clear_a();
        for (int i = 0; i < 256; i++) ref_a[i] = 32'h0;
        exp_do  = 32'h0;
        exp_vld = 1'b0;
    endtask

    // Applies one accepted request: the read sees the word before the write.
    task automatic model_a(input logic wr, input logic rd, input logic [7:0] addr,
                           input logic [3:0] bm, input logic [31:0] din);
        logic [31:0] mask;
        if (rd) begin
            exp_do  = ref_a[addr];
            exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bm[i]) begin
                    mask        = 32'hFF << (8 * i);
                    ref_a[addr] = (ref_a[addr] & ~mask) | (din & mask);
                end
            end
        end
    endtask

    // One clock of stimulus on instance a; outputs are settled 1 time unit later.
    task automatic cyc_a(input logic wr, input logic rd, input logic [7:0] addr,
                         input logic [3:0] bm, input logic [31:0] din);
        a_WR = wr; a_RD = rd; a_address = addr; a_be = bm; a_Din = din;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input logic wr, input logic rd, input logic [7:0] addr,
                         input logic [3:0] bm, input logic [31:0] din);
        b_WR = wr; b_RD = rd; b_address = addr; b_be = bm; b_Din = din;
        @(posedge clk);
        #1;
    endtask

    // Accepted request on a, mirrored into the model.
    task automatic op_a(input logic wr, input logic rd, input logic [7:0] addr,
                        input logic [3:0] bm, input logic [31:0] din);
        model_a(wr, rd, addr, bm, din);
        cyc_a(wr, rd, addr, bm, din);
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        cyc_a(1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
        checks++;
        if (a_Do !== 32'h0 || a_rd_valid !== 1'b0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_a: Do=%h rd_valid=%b ready=%b, expected 0/0/0", a_Do, a_rd_valid, a_ready);
        end
        checks++;
        if (b_Do !== 32'h0 || b_rd_valid !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_b: Do=%h rd_valid=%b ready=%b, expected 0/0/0", b_Do, b_rd_valid, b_ready);
        end
        a_rst = 1'b0; b_rst = 1'b0;
        model_clear_a();
        // ready must rise exactly DEPTH edges after rst falls, on each instance.
        for (int k = 1; k <= 256; k++) begin
            cyc_a(1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
            checks++;
            if (a_ready !== (k == 256)) begin
                errors++;
                $display("FAIL clear_ready_a edge %0d: ready=%b expected %b", k, a_ready, (k == 256));
            end
            checks++;
            if (b_ready !== (k >= 200)) begin
                errors++;
                $display("FAIL clear_ready_b edge %0d: ready=%b expected %b", k, b_ready, (k >= 200));
            end
        end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] addr;
            addr = (i == 0) ? 8'd0 : (i == 1) ? 8'd4 : 8'd255;
            op_a(1'b0, 1'b1, addr, 4'h0, 32'h0);
            checks++;
            if (a_Do !== 32'h0 || a_rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL cleared_read addr %0d: Do=%h rd_valid=%b expected 00000000/1", addr, a_Do, a_rd_valid);
            end
        end
        op_a(1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
        checks++;
        if (a_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_drop: rd_valid=%b expected 0", a_rd_valid);
        end
    endtask

    task automatic test_full_rw();
        op_a(1'b1, 1'b0, 8'd0, 4'hF, 32'h1215_3524);
        op_a(1'b1, 1'b0, 8'd4, 4'hF, 32'hC089_5E81);
        op_a(1'b0, 1'b1, 8'd0, 4'h0, 32'h0);
        checks++;
        if (a_Do !== 32'h1215_3524 || a_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_rw addr0: Do=%h rd_valid=%b expected 12153524/1", a_Do, a_rd_valid);
        end
        op_a(1'b0, 1'b1, 8'd4, 4'h0, 32'h0);
        checks++;
        if (a_Do !== 32'hC089_5E81 || a_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_rw addr4: Do=%h rd_valid=%b expected c0895e81/1", a_Do, a_rd_valid);
        end
        op_a(1'b0, 1'b0, 8'd9, 4'h0, 32'h0);
        checks++;
        if (a_Do !== 32'hC089_5E81 || a_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL do_hold: Do=%h rd_valid=%b expected c0895e81/0", a_Do, a_rd_valid);
        end
    endtask

    task automatic test_byte_lanes();
        op_a(1'b1, 1'b0, 8'd8, 4'hF, 32'hAABB_CCDD);
        op_a(1'b1, 1'b0, 8'd8, 4'b0101, 32'h1122_3344);
        op_a(1'b1, 1'b0, 8'd8, 4'b0000, 32'hFFFF_FFFF);
        op_a(1'b0, 1'b1, 8'd8, 4'h0, 32'h0);
        checks++;
        if (a_Do !== 32'hAA22_CC44 || a_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL byte_lanes: Do=%h rd_valid=%b expected aa22cc44/1", a_Do, a_rd_valid);
        end
    endtask

    task automatic test_rd_wr_same();
        op_a(1'b1, 1'b1, 8'd4, 4'hF, 32'hDEAD_BEEF);
        checks++;
        if (a_Do !== 32'hC089_5E81 || a_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd_wr_same old: Do=%h rd_valid=%b expected c0895e81/1", a_Do, a_rd_valid);
        end
        op_a(1'b0, 1'b1, 8'd4, 4'h0, 32'h0);
        checks++;
        if (a_Do !== 32'hDEAD_BEEF || a_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd_wr_same new: Do=%h rd_valid=%b expected deadbeef/1", a_Do, a_rd_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic       wr, rd;
            logic [7:0] addr;
            logic [3:0] bm;
            logic [31:0] din;
            wr   = 1'($urandom_range(0, 1));
            rd   = 1'($urandom_range(0, 1));
            addr = (n % 2 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            bm   = 4'($urandom_range(0, 15));
            din  = $urandom;
            op_a(wr, rd, addr, bm, din);
            checks++;
            if (a_Do !== exp_do || a_rd_valid !== exp_vld) begin
                errors++;
                $display("FAIL random op %0d addr %0d: Do=%h rd_valid=%b expected %h/%b", n, addr, a_Do, a_rd_valid, exp_do, exp_vld);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        a_rst = 1'b1;
        cyc_a(1'b0, 1'b0, 8'd0, 4'h0, 32'h0);
        a_rst = 1'b0;
        for (int k = 1; k < 100; k++) cyc_a(1'b1, 1'b1, 8'd3, 4'hF, 32'h1234_5678);
        a_rst = 1'b1;
        cyc_a(1'b1, 1'b1, 8'd3, 4'hF, 32'h1234_5678);
        a_rst = 1'b0;
        checks++;
        if (a_ready !== 1'b0 || a_rd_valid !== 1'b0 || a_Do !== 32'h0) begin
            errors++;
            $display("FAIL mid_clear_reset: ready=%b rd_valid=%b Do=%h expected 0/0/0", a_ready, a_rd_valid, a_Do);
        end
        model_clear_a();
        for (int k = 1; k <= 256; k++) begin
            cyc_a(1'b1, 1'b1, 8'd3, 4'hF, 32'h1234_5678);
            checks++;
            if (a_ready !== (k == 256) || a_rd_valid !== 1'b0 || a_Do !== 32'h0) begin
                errors++;
                $display("FAIL restart_clear edge %0d: ready=%b rd_valid=%b Do=%h expected %b/0/0", k, a_ready, a_rd_valid, a_Do, (k == 256));
            end
        end
        for (int i = 0; i < 2; i++) begin
            logic [7:0] addr;
            addr = (i == 0) ? 8'd3 : 8'd8;
            op_a(1'b0, 1'b1, addr, 4'h0, 32'h0);
            checks++;
            if (a_Do !== 32'h0 || a_rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL reclear_read addr %0d: Do=%h rd_valid=%b expected 00000000/1", addr, a_Do, a_rd_valid);
            end
        end
    endtask

    task automatic test_small_depth();
        cyc_b(1'b0, 1'b1, 8'd0, 4'h0, 32'h0);
        checks++;
        if (b_Do !== c_init_b || b_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL init_val_b: Do=%h rd_valid=%b expected %h/1", b_Do, b_rd_valid, c_init_b);
        end
        cyc_b(1'b1, 1'b0, 8'd210, 4'hF, 32'h5);
        cyc_b(1'b0, 1'b1, 8'd210, 4'h0, 32'h0);
        checks++;
        if (b_Do !== 32'h0 || b_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: Do=%h rd_valid=%b expected 00000000/1", b_Do, b_rd_valid);
        end
        // A dropped write must not alias onto a low address.
        cyc_b(1'b0, 1'b1, 8'd10, 4'h0, 32'h0);
        checks++;
        if (b_Do !== c_init_b || b_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL oor_no_alias: Do=%h rd_valid=%b expected %h/1", b_Do, b_rd_valid, c_init_b);
        end
        cyc_b(1'b1, 1'b0, 8'd199, 4'hF, 32'h5);
        cyc_b(1'b0, 1'b1, 8'd199, 4'h0, 32'h0);
        checks++;
        if (b_Do !== 32'h5 || b_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL last_word_b: Do=%h rd_valid=%b expected 00000005/1", b_Do, b_rd_valid);
        end
        cyc_b(1'b0, 1'b0, 8'd0, 4'h0, 32'h0);
    endtask

    initial begin
        a_rst = 1'b1; a_WR = 1'b0; a_RD = 1'b0; a_address = '0; a_be = '0; a_Din = '0;
        b_rst = 1'b1; b_WR = 1'b0; b_RD = 1'b0; b_address = '0; b_be = '0; b_Din = '0;
        exp_do = '0; exp_vld = 1'b0;
        test_reset();
        test_full_rw();
        test_byte_lanes();
        test_rd_wr_same();
        test_random();
        test_reset_mid_clear();
        test_small_depth();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
